uart_cfg_hex_dump_sequencer: RTL

- Feeds the byte-transmit stage: takes a snapshot of the config bus and serializes it as uppercase ASCII hex, MSB nibble first, followed by CR LF.
- Drives one byte at a time over the txData8/txStart/txBusy handshake into the UART transmitter.
- Runs in the UART bit-clock domain, the same clock that drives the transmitter.

---
 rtl/uart_cfg_hex_dump_sequencer_pkg.sv | 18 +
 rtl/hex_nibble_to_ascii.sv | 18 +
 rtl/uart_cfg_hex_dump_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_cfg_hex_dump_sequencer_pkg.sv
// Shared constants and state encoding for the config-bus hex dump sequencer.
package uart_cfg_hex_dump_sequencer_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSend   = 3'd1,
        StWaitHi = 3'd2,
        StWaitLo = 3'd3,
        StNext   = 3'd4,
        StDone   = 3'd5
    } state_e;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Maps one 4-bit value to its uppercase ASCII hex character.
module hex_nibble_to_ascii
    import uart_cfg_hex_dump_sequencer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Digits 0-9 and letters A-F live in separate ASCII ranges
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'b0000, nibble};
        end else begin
            ascii = ASCII_A + {4'b0000, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_cfg_hex_dump_sequencer.sv
// Snapshots the config bus and streams it as uppercase hex plus CR LF, one byte
// per txStart/txBusy handshake with the UART transmitter.
module uart_cfg_hex_dump_sequencer
    import uart_cfg_hex_dump_sequencer_pkg::*;
#(
    parameter int unsigned BUS_W       = 32,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             dumpReq,
    input  logic [BUS_W-1:0] busIn,
    input  logic             txBusy,
    output logic [7:0]       txData8,
    output logic             txStart,
    output logic             dumpBusy,
    output logic             dumpDone
);

    localparam int unsigned NIB   = BUS_W / 4;
    localparam int unsigned IDX_W = $clog2(NIB + 2);
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);

    state_e             state_q, state_d;
    logic [BUS_W-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;

    logic [BUS_W-1:0]   load_word;
    logic [IDX_W-1:0]   load_idx;
    logic [3:0]         load_nib;
    logic [7:0]         hex_char;
    logic [7:0]         load_char;

    // Word/index of the character loaded on entry to SEND (bus itself when accepting)
    always_comb begin
        load_word = snap_q;
        load_idx  = idx_q + IDX_W'(1);
        if (state_q == StIdle) begin
            load_word = busIn;
            load_idx  = '0;
        end
    end

    // MSB nibble first
    always_comb begin
        load_nib = '0;
        for (int k = 0; k < int'(NIB); k++) begin
            if (load_idx == IDX_W'(k)) begin
                load_nib = load_word[BUS_W-1-4*k -: 4];
            end
        end
    end

    hex_nibble_to_ascii u_hex (
        .nibble (load_nib),
        .ascii  (hex_char)
    );

    // Hex characters first, then the CR LF trailer
    always_comb begin
        if (load_idx == IDX_W'(NIB)) begin
            load_char = ASCII_CR;
        end else if (load_idx == IDX_W'(NIB + 1)) begin
            load_char = ASCII_LF;
        end else begin
            load_char = hex_char;
        end
    end

    // Next-state and strobe logic; txData8 is loaded as SEND is entered
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        txStart = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dumpReq) begin
                    snap_d  = busIn;
                    idx_d   = '0;
                    data_d  = load_char;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!txBusy) begin
                    txStart = 1'b1;
                    cnt_d   = '0;
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                if (txBusy) begin
                    state_d = StWaitLo;
                end else begin
                    // Lost-ack recovery: move on if the transmitter never answers
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(ACK_TIMEOUT - 1)) begin
                        state_d = StNext;
                    end
                end
            end
            StWaitLo: begin
                if (!txBusy) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q == IDX_W'(NIB + 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    data_d  = load_char;
                    state_d = StSend;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= StIdle;
            snap_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign txData8  = data_q;
    assign dumpBusy = (state_q != StIdle) && (state_q != StDone);
    assign dumpDone = (state_q == StDone);

endmodule
